// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle around the fetch queue
//
// Purpose: groups the fetch-side push channel, the decode-side head channel,
// and the flush/stall controls of fetch_queue into one interface.
// Parameters:
//   DEPTH   queue entries (power of two, >= 2); sets the width of count_o
//   XCPT_W  width of the fetch exception code
// Signals (directions as seen by the queue, modport slave):
//   flush_i      in   committed taken branch, empties the queue
//   valid_i      in   fetch presents an instruction
//   pc_i         in   PC of the fetched instruction
//   instr_i      in   instruction word
//   kanata_id_i  in   trace id
//   xcpt_i       in   fetch exception flag
//   xcpt_code_i  in   fetch exception code
//   ready_o      out  queue accepts a push this cycle
//   stall_i      in   decode stall, head is held while high
//   valid_o      out  head entry valid
//   pc_o, instr_o, kanata_id_o, xcpt_o, xcpt_code_o  out  head payload
//   count_o      out  number of valid entries
//   full_o       out  count_o == DEPTH
//   empty_o      out  count_o == 0
// modport master is the mirror image used by the fetch/decode side.

interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int XCPT_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush_i;
    logic              valid_i;
    logic [31:0]       pc_i;
    logic [31:0]       instr_i;
    logic [31:0]       kanata_id_i;
    logic              xcpt_i;
    logic [XCPT_W-1:0] xcpt_code_i;
    logic              ready_o;
    logic              stall_i;
    logic              valid_o;
    logic [31:0]       pc_o;
    logic [31:0]       instr_o;
    logic [31:0]       kanata_id_o;
    logic              xcpt_o;
    logic [XCPT_W-1:0] xcpt_code_o;
    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              empty_o;

    modport slave (
        input  flush_i, valid_i, pc_i, instr_i, kanata_id_i, xcpt_i, xcpt_code_i, stall_i,
        output ready_o, valid_o, pc_o, instr_o, kanata_id_o, xcpt_o, xcpt_code_o,
               count_o, full_o, empty_o
    );

    modport master (
        output flush_i, valid_i, pc_i, instr_i, kanata_id_i, xcpt_i, xcpt_code_i, stall_i,
        input  ready_o, valid_o, pc_o, instr_o, kanata_id_o, xcpt_o, xcpt_code_o,
               count_o, full_o, empty_o
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction queue between fetch and decode
//
// Purpose: buffers up to DEPTH fetched instructions (pc, instr, kanata id,
// exception flag and code) so fetch keeps running while decode stalls.
// A flush (committed taken branch) or reset empties the queue at the next edge.
// Ports:
//   clk_i   in  core clock, all state changes on the rising edge
//   rstn_i  in  synchronous active-low reset, overrides every other input
//   bus     fetch_queue_if.slave, push channel, head channel, flush/stall, status

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int XCPT_W = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]       r_pc        [DEPTH];
    logic [31:0]       r_instr     [DEPTH];
    logic [31:0]       r_kanata_id [DEPTH];
    logic              r_xcpt      [DEPTH];
    logic [XCPT_W-1:0] r_xcpt_code [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // ready is taken from the count alone: a full queue refuses a push even
    // when the head leaves in the same cycle, keeping ready_o off the stall path.
    assign w_push = bus.valid_i & ~w_full & ~bus.flush_i;
    assign w_pop  = ~w_empty & ~bus.stall_i & ~bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is never cleared; stale entries are hidden by the count.
    always_ff @(posedge clk_i) begin
        if (rstn_i && w_push) begin
            r_pc[r_tail]        <= bus.pc_i;
            r_instr[r_tail]     <= bus.instr_i;
            r_kanata_id[r_tail] <= bus.kanata_id_i;
            r_xcpt[r_tail]      <= bus.xcpt_i;
            r_xcpt_code[r_tail] <= bus.xcpt_code_i;
        end
    end

    assign bus.ready_o     = ~w_full;
    assign bus.valid_o     = ~w_empty;
    assign bus.full_o      = w_full;
    assign bus.empty_o     = w_empty;
    assign bus.count_o     = r_count;

    // Head payload reads as zero when the queue is empty so decode never sees
    // a stale instruction or exception.
    assign bus.pc_o        = w_empty ? '0 : r_pc[r_head];
    assign bus.instr_o     = w_empty ? '0 : r_instr[r_head];
    assign bus.kanata_id_o = w_empty ? '0 : r_kanata_id[r_head];
    assign bus.xcpt_o      = w_empty ? 1'b0 : r_xcpt[r_head];
    assign bus.xcpt_code_o = w_empty ? '0 : r_xcpt_code[r_head];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XW    = 4;
    localparam logic [3:0] XCPT_INSTR_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] XCPT_INSTR_ACCESS_FAULT    = 4'd1;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .XCPT_W(XW)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XCPT_W(XW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] kid;
        logic        x;
        logic [3:0]  code;
    } ent_t;

    ent_t        src_q[$];   // instructions fetch still wants to deliver
    ent_t        m_q[$];     // reference queue contents
    logic [31:0] dut_out[$]; // PCs the DUT handed to decode
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          cmp_en   = 1'b0;
    int          max_cnt  = 0;
    int          kid_ctr  = 1;
    bit          m_push;
    bit          m_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic x, input logic [3:0] code);
        ent_t e;
        e.pc    = pc;
        e.instr = (pc * 3) ^ 32'h0000_0013;
        e.kid   = kid_ctr;
        kid_ctr++;
        e.x     = x;
        e.code  = code;
        src_q.push_back(e);
    endtask

    // Fetch side: presents the oldest pending instruction and holds it until taken.
    task automatic tick(input logic stall, input logic flush, input logic rn);
        @(negedge clk);
        rstn        = rn;
        bus.stall_i = stall;
        bus.flush_i = flush;
        if (src_q.size() > 0) begin
            bus.valid_i     = 1'b1;
            bus.pc_i        = src_q[0].pc;
            bus.instr_i     = src_q[0].instr;
            bus.kanata_id_i = src_q[0].kid;
            bus.xcpt_i      = src_q[0].x;
            bus.xcpt_code_i = src_q[0].code;
        end else begin
            bus.valid_i     = 1'b0;
            bus.pc_i        = '0;
            bus.instr_i     = '0;
            bus.kanata_id_i = '0;
            bus.xcpt_i      = 1'b0;
            bus.xcpt_code_i = '0;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reference behaviour: a FIFO of at most DEPTH entries; ready depends only
    // on occupancy before the edge; flush/reset empty it and drop that cycle's traffic.
    always @(posedge clk) begin
        m_push = bus.valid_i && (m_q.size() < DEPTH) && !bus.flush_i;
        m_pop  = (m_q.size() != 0) && !bus.stall_i && !bus.flush_i;
        if (rstn !== 1'b1) begin
            m_q.delete();
        end else if (bus.flush_i) begin
            m_q.delete();
            src_q.delete(); // fetch is redirected by the taken branch
        end else begin
            if (m_pop)  void'(m_q.pop_front());
            if (m_push) m_q.push_back(src_q.pop_front());
        end
    end

    always @(negedge clk) begin
        #3;
        if (cmp_en) begin
            chk("ready_o", bus.ready_o, m_q.size() < DEPTH);
            chk("valid_o", bus.valid_o, m_q.size() != 0);
            chk("count_o", bus.count_o, m_q.size());
            chk("full_o",  bus.full_o,  m_q.size() == DEPTH);
            chk("empty_o", bus.empty_o, m_q.size() == 0);
            if (m_q.size() != 0) begin
                chk("pc_o",        bus.pc_o,        m_q[0].pc);
                chk("instr_o",     bus.instr_o,     m_q[0].instr);
                chk("kanata_id_o", bus.kanata_id_o, m_q[0].kid);
                chk("xcpt_o",      bus.xcpt_o,      m_q[0].x);
                chk("xcpt_code_o", bus.xcpt_code_o, m_q[0].code);
            end else begin
                chk("pc_o_empty",        bus.pc_o,        0);
                chk("instr_o_empty",     bus.instr_o,     0);
                chk("kanata_id_o_empty", bus.kanata_id_o, 0);
                chk("xcpt_o_empty",      bus.xcpt_o,      0);
                chk("xcpt_code_o_empty", bus.xcpt_code_o, 0);
            end
            if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
            if (rstn && bus.valid_o && !bus.stall_i && !bus.flush_i)
                dut_out.push_back(bus.pc_o);
        end
    end

    initial begin
        rstn            = 1'b0;
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.valid_i     = 1'b0;
        bus.pc_i        = '0;
        bus.instr_i     = '0;
        bus.kanata_id_i = '0;
        bus.xcpt_i      = 1'b0;
        bus.xcpt_code_i = '0;

        // Reset then idle
        tick(0, 0, 0);
        tick(0, 0, 0);
        settle();
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_ready_o", bus.ready_o, 1);
        chk("rst_count_o", bus.count_o, 0);
        chk("rst_empty_o", bus.empty_o, 1);
        chk("rst_full_o",  bus.full_o,  0);
        chk("rst_instr_o", bus.instr_o, 0);
        cmp_en = 1'b1;

        // Streaming at one per cycle
        dut_out.delete();
        max_cnt = 0;
        add(32'h0, 0, 0); add(32'h4, 0, 0); add(32'h8, 0, 0); add(32'hC, 0, 0);
        tick(0, 0, 1);
        settle();
        chk("stream_first_valid", bus.valid_o, 1);
        chk("stream_first_pc",    bus.pc_o,    32'h0);
        repeat (5) tick(0, 0, 1);
        settle();
        chk("stream_n_out", dut_out.size(), 4);
        if (dut_out.size() == 4) begin
            chk("stream_pc0", dut_out[0], 32'h0);
            chk("stream_pc1", dut_out[1], 32'h4);
            chk("stream_pc2", dut_out[2], 32'h8);
            chk("stream_pc3", dut_out[3], 32'hC);
        end
        chk("stream_max_count", max_cnt, 1);

        // Fill under stall, then release: simultaneous push/pop at full, wrap-around
        dut_out.delete();
        add(32'h100, 0, 0); add(32'h104, 0, 0); add(32'h108, 0, 0);
        add(32'h10C, 0, 0); add(32'h110, 0, 0);
        repeat (5) tick(1, 0, 1);
        settle();
        chk("fill_count",   bus.count_o, 4);
        chk("fill_full",    bus.full_o,  1);
        chk("fill_ready",   bus.ready_o, 0);
        chk("fill_head_pc", bus.pc_o,    32'h100);
        chk("fill_held",    src_q.size(), 1);
        tick(0, 0, 1);
        settle();
        chk("full_pop_count", bus.count_o, 3);
        chk("full_pop_ready", bus.ready_o, 1);
        tick(0, 0, 1);
        settle();
        chk("pushpop_count", bus.count_o, 3);
        chk("pushpop_head",  bus.pc_o,    32'h108);
        repeat (4) tick(0, 0, 1);
        settle();
        chk("fill_n_out", dut_out.size(), 5);
        if (dut_out.size() == 5) begin
            chk("fill_pc0", dut_out[0], 32'h100);
            chk("fill_pc1", dut_out[1], 32'h104);
            chk("fill_pc2", dut_out[2], 32'h108);
            chk("fill_pc3", dut_out[3], 32'h10C);
            chk("fill_pc4", dut_out[4], 32'h110);
        end

        // Flush with a push presented and stall low
        dut_out.delete();
        add(32'h300, 0, 0); add(32'h304, 0, 0); add(32'h308, 0, 0);
        repeat (3) tick(1, 0, 1);
        settle();
        chk("pre_flush_count", bus.count_o, 3);
        add(32'h30C, 0, 0);
        tick(0, 1, 1);
        settle();
        chk("flush_count", bus.count_o, 0);
        chk("flush_valid", bus.valid_o, 0);
        chk("flush_ready", bus.ready_o, 1);
        chk("flush_no_pop", dut_out.size(), 0);
        add(32'h200, 0, 0);
        tick(0, 0, 1);
        settle();
        chk("post_flush_valid", bus.valid_o, 1);
        chk("post_flush_pc",    bus.pc_o,    32'h200);
        chk("post_flush_count", bus.count_o, 1);
        repeat (2) tick(0, 0, 1);

        // Flush while full and stalled
        add(32'h600, 0, 0); add(32'h604, 0, 0); add(32'h608, 0, 0); add(32'h60C, 0, 0);
        repeat (4) tick(1, 0, 1);
        tick(1, 1, 1);
        settle();
        chk("flush_full_count", bus.count_o, 0);
        chk("flush_full_ready", bus.ready_o, 1);

        // Exception entries pass through in order
        add(32'h400, 0, 0);
        add(32'h102, 1, XCPT_INSTR_ADDR_MISALIGNED);
        add(32'h108, 1, XCPT_INSTR_ACCESS_FAULT);
        repeat (3) tick(1, 0, 1);
        settle();
        chk("xc_head0_pc",   bus.pc_o,   32'h400);
        chk("xc_head0_xcpt", bus.xcpt_o, 0);
        tick(0, 0, 1);
        settle();
        chk("xc_head1_pc",   bus.pc_o,        32'h102);
        chk("xc_head1_xcpt", bus.xcpt_o,      1);
        chk("xc_head1_code", bus.xcpt_code_o, XCPT_INSTR_ADDR_MISALIGNED);
        tick(0, 0, 1);
        settle();
        chk("xc_head2_pc",   bus.pc_o,        32'h108);
        chk("xc_head2_xcpt", bus.xcpt_o,      1);
        chk("xc_head2_code", bus.xcpt_code_o, XCPT_INSTR_ACCESS_FAULT);
        repeat (2) tick(0, 0, 1);

        // Reset mid-stream, then first push accepted right after release
        add(32'h500, 0, 0); add(32'h504, 0, 0); add(32'h508, 0, 0); add(32'h50C, 0, 0);
        repeat (2) tick(1, 0, 1);
        tick(1, 0, 0);
        settle();
        chk("midrst_count", bus.count_o, 0);
        chk("midrst_valid", bus.valid_o, 0);
        tick(0, 0, 1);
        settle();
        chk("postrst_count", bus.count_o, 1);
        chk("postrst_pc",    bus.pc_o,    32'h508);
        repeat (4) tick(0, 0, 1);
        settle();
        chk("final_empty", bus.empty_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
